// File: rtl/patch_stim_gen.sv
// Stimulus source for the patch/weighted-sum path: emits (patch_num, wtsum) beats
// from an XNOR LFSR or a sequential patch counter, seeded and length-limited or free-running.
module patch_stim_gen #(
  parameter int          DELAY   = 1,
  parameter int          LFSR_W  = 12,
  parameter logic [LFSR_W-1:0] TAPS = 12'hE08,
  parameter int          N_PATCH = 600000,
  parameter int          PN_W    = 20,
  parameter int          FP_SIZE = 20,
  parameter logic [3:0]  EXP     = 4'b1000,
  parameter int          CNT_W   = 32
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic               mode,
  input  logic [LFSR_W-1:0]  seed,
  input  logic [CNT_W-1:0]   count,
  input  logic               stop,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PN_W-1:0]    patch_num,
  output logic [FP_SIZE-1:0] wtsum,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   beats_sent,
  output logic [1:0]         dbg_state
);

  // valid/ready: a beat transfers on any cycle with out_valid && out_ready; once raised,
  // out_valid and the beat hold until that transfer, unless stop or RESET ends the stream.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [PN_W-1:0] PN_LAST = PN_W'(N_PATCH - 1);

  state_t               state_q, state_d;
  logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
  logic [PN_W-1:0]      pcnt_q, pcnt_d;
  logic                 mode_q, mode_d;
  logic                 free_q, free_d;
  logic [CNT_W-1:0]     rem_q, rem_d;
  logic [CNT_W-1:0]     beats_q, beats_d;
  logic [PN_W-1:0]      pn_q, pn_d;
  logic [FP_SIZE-1:0]   ws_q, ws_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [LFSR_W-1:0]    seed_fix;
  logic [LFSR_W-1:0]    lfsr_nx;
  logic [PN_W-1:0]      pcnt_nx;
  logic                 accept;
  logic                 last_beat;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ~^(l & TAPS)};
  endfunction

  // Sign-like MSB, fixed exponent, remaining LFSR bits, zero-padded at the LSB end.
  function automatic logic [FP_SIZE-1:0] fmt_wtsum(input logic [LFSR_W-1:0] l);
    logic [LFSR_W+3:0] core;
    core = {l[LFSR_W-1], EXP, l[LFSR_W-2:0]};
    return FP_SIZE'(core) << (FP_SIZE - LFSR_W - 4);
  endfunction

  always_comb begin
    // An all-ones seed would lock the XNOR LFSR, so it is replaced by zero.
    seed_fix  = (&seed) ? '0 : seed;
    lfsr_nx   = lfsr_step(lfsr_q);
    pcnt_nx   = (pcnt_q == PN_LAST) ? '0 : pcnt_q + 1'b1;
    accept    = valid_q && out_ready;
    last_beat = accept && !free_q && (rem_q == CNT_W'(1));

    state_d = state_q;
    lfsr_d  = lfsr_q;
    pcnt_d  = pcnt_q;
    mode_d  = mode_q;
    free_d  = free_q;
    rem_d   = rem_q;
    beats_d = beats_q;
    pn_d    = pn_q;
    ws_d    = ws_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          lfsr_d  = seed_fix;
          pcnt_d  = '0;
          mode_d  = mode;
          free_d  = (count == '0);
          rem_d   = count;
          beats_d = '0;
          pn_d    = mode ? '0 : PN_W'(seed_fix);
          ws_d    = fmt_wtsum(seed_fix);
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (accept) begin
          lfsr_d  = lfsr_nx;
          pcnt_d  = pcnt_nx;
          beats_d = beats_q + 1'b1;
          if (!free_q) rem_d = rem_q - 1'b1;
          pn_d    = mode_q ? pcnt_nx : PN_W'(lfsr_nx);
          ws_d    = fmt_wtsum(lfsr_nx);
        end
        if (stop || last_beat) begin
          state_d = S_DONE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pn_d    = '0;
          ws_d    = '0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      lfsr_q  <= '0;
      pcnt_q  <= '0;
      mode_q  <= 1'b0;
      free_q  <= 1'b0;
      rem_q   <= '0;
      beats_q <= '0;
      pn_q    <= '0;
      ws_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      pcnt_q  <= pcnt_d;
      mode_q  <= mode_d;
      free_q  <= free_d;
      rem_q   <= rem_d;
      beats_q <= beats_d;
      pn_q    <= pn_d;
      ws_q    <= ws_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_valid  = valid_q;
  assign patch_num  = pn_q;
  assign wtsum      = ws_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign beats_sent = beats_q;
  assign dbg_state  = state_q;

  // LFSR values must stay inside the patch range when used directly as patch_num.
  assert property (@(posedge CLK) disable iff (RESET)
    (valid_q && !mode_q) |-> (DELAY >= 0 && (2 ** LFSR_W) <= N_PATCH))
    else $error("LFSR range exceeds N_PATCH in LFSR mode");

endmodule

// File: tb/tb_patch_stim_gen.sv
// Bench for patch_stim_gen: directed streams checked against a queue-based beat model
// plus hand-computed literal beats; a second instance with N_PATCH=2 covers counter wrap.
module tb_patch_stim_gen;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start, mode, stop, out_ready;
  logic [11:0] seed;
  logic [31:0] count;
  logic        out_valid, busy, done;
  logic [19:0] patch_num, wtsum;
  logic [31:0] beats_sent;
  logic [1:0]  dbg;

  logic        w_start, w_mode, w_stop, w_ready;
  logic [11:0] w_seed;
  logic [31:0] w_count;
  logic        w_valid, w_busy, w_done;
  logic [19:0] w_pn, w_ws;
  logic [31:0] w_beats;
  logic [1:0]  w_dbg;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  logic [31:0] exp_pn_q[$];
  logic [31:0] exp_ws_q[$];

  patch_stim_gen dut (
    .CLK(CLK), .RESET(RESET), .start(start), .mode(mode), .seed(seed), .count(count),
    .stop(stop), .out_valid(out_valid), .out_ready(out_ready), .patch_num(patch_num),
    .wtsum(wtsum), .busy(busy), .done(done), .beats_sent(beats_sent), .dbg_state(dbg)
  );

  patch_stim_gen #(.N_PATCH(2)) dut_w (
    .CLK(CLK), .RESET(RESET), .start(w_start), .mode(w_mode), .seed(w_seed), .count(w_count),
    .stop(w_stop), .out_valid(w_valid), .out_ready(w_ready), .patch_num(w_pn),
    .wtsum(w_ws), .busy(w_busy), .done(w_done), .beats_sent(w_beats), .dbg_state(w_dbg)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: LFSR as plain arithmetic, wtsum assembled by weights.
  function automatic int model_lfsr_next(input int l);
    int fb;
    fb = ($countones(l & 'hE08) % 2 == 0) ? 1 : 0;
    return ((l << 1) & 'hFFF) | fb;
  endfunction

  function automatic int model_wtsum(input int l);
    return ((l >> 11) & 1) * 'h80000 + 'h40000 + (l & 'h7FF) * 16;
  endfunction

  task automatic model_stream(input int s, input bit m, input int n, input int npatch);
    int l;
    l = (s == 'hFFF) ? 0 : s;
    for (int i = 0; i < n; i++) begin
      exp_pn_q.push_back(m ? (i % npatch) : l);
      exp_ws_q.push_back(model_wtsum(l));
      l = model_lfsr_next(l);
    end
  endtask

  // Scoreboard: every valid cycle shows the head of the queue; an accept pops it.
  always @(negedge CLK) begin
    if (out_valid === 1'b1) begin
      if (exp_pn_q.size() == 0) begin
        chk("extra_beat", 32'(patch_num), 32'hFFFF_FFFF);
      end else begin
        chk("sb_patch_num", 32'(patch_num), exp_pn_q[0]);
        chk("sb_wtsum", 32'(wtsum), exp_ws_q[0]);
        if (out_ready === 1'b1) begin
          void'(exp_pn_q.pop_front());
          void'(exp_ws_q.pop_front());
          acc_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic start_stream(input int s, input int c, input bit m, input int nmodel);
    seed = 12'(s); count = c; mode = m; start = 1'b1;
    model_stream(s, m, nmodel, 600000);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge CLK);
      if (done === 1'b1) seen = 1'b1;
      tick();
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic flush_model();
    exp_pn_q.delete();
    exp_ws_q.delete();
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lit_pn[5];
    logic [31:0] lit_ws[5];
    logic [31:0] lit_stall[7];
    logic        rdy_pat[7];
    logic [31:0] lit_wrap[3];
    int          acc0;

    lit_pn    = '{32'h000, 32'h001, 32'h003, 32'h007, 32'h00F};
    lit_ws    = '{32'h40000, 32'h40010, 32'h40030, 32'h40070, 32'h400F0};
    lit_stall = '{0, 1, 1, 1, 2, 3, 3};
    rdy_pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    lit_wrap  = '{0, 1, 0};

    RESET = 1'b1; start = 1'b0; mode = 1'b0; stop = 1'b0; out_ready = 1'b1;
    seed = '0; count = '0;
    w_start = 1'b0; w_mode = 1'b1; w_stop = 1'b0; w_ready = 1'b1; w_seed = '0; w_count = '0;
    repeat (3) tick();
    @(negedge CLK);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_patch_num", 32'(patch_num), 0);
    chk("rst_wtsum", 32'(wtsum), 0);
    chk("rst_beats", beats_sent, 0);
    chk("rst_state", 32'(dbg), 0);
    tick();
    RESET = 1'b0;
    tick();

    // Seed 0, five beats in LFSR mode, consumer always ready.
    start_stream(0, 5, 1'b0, 5);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("s1_busy", 32'(busy), 1);
      chk("s1_patch_num", 32'(patch_num), lit_pn[i]);
      chk("s1_wtsum", 32'(wtsum), lit_ws[i]);
      tick();
    end
    @(negedge CLK);
    chk("s1_done", 32'(done), 1);
    chk("s1_valid_low", 32'(out_valid), 0);
    chk("s1_busy_low", 32'(busy), 0);
    chk("s1_beats", beats_sent, 5);
    tick();
    @(negedge CLK);
    chk("s1_done_pulse", 32'(done), 0);
    repeat (3) tick();
    chk("s1_beats_hold", beats_sent, 5);
    chk("s1_queue_empty", exp_pn_q.size(), 0);

    // Lock-up seed substitution and MSB placement in wtsum.
    start_stream('hFFF, 1, 1'b0, 1);
    @(negedge CLK);
    chk("s2_lockup_pn", 32'(patch_num), 32'h000);
    chk("s2_lockup_ws", 32'(wtsum), 32'h40000);
    tick();
    wait_done("s2_done_a", 5);
    tick();
    start_stream('h800, 1, 1'b0, 1);
    @(negedge CLK);
    chk("s2_msb_pn", 32'(patch_num), 32'h800);
    chk("s2_msb_ws", 32'(wtsum), 32'hC0000);
    tick();
    wait_done("s2_done_b", 5);
    tick();

    // Sequential mode with stalls: beat must hold until accepted.
    acc0 = acc_cnt;
    start_stream('h005, 4, 1'b1, 4);
    for (int i = 0; i < 7; i++) begin
      out_ready = rdy_pat[i];
      @(negedge CLK);
      chk("s3_valid", 32'(out_valid), 1);
      chk("s3_patch_num", 32'(patch_num), lit_stall[i]);
      tick();
    end
    out_ready = 1'b1;
    @(negedge CLK);
    chk("s3_done", 32'(done), 1);
    chk("s3_beats", beats_sent, 4);
    chk("s3_accepts", acc_cnt - acc0, 4);
    tick();

    // Counter wrap with N_PATCH=2.
    w_count = 3; w_seed = 12'h00A; w_start = 1'b1;
    tick();
    w_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("s4_valid", 32'(w_valid), 1);
      chk("s4_patch_num", 32'(w_pn), lit_wrap[i]);
      tick();
    end
    @(negedge CLK);
    chk("s4_done", 32'(w_done), 1);
    chk("s4_beats", w_beats, 3);
    tick();

    // Free-run, stop with the 10th accept; a start mid-run must be ignored.
    acc0 = acc_cnt;
    start_stream('h123, 0, 1'b0, 16);
    for (int i = 0; i < 10; i++) begin
      start = (i == 5);
      seed  = 12'h456;
      stop  = (i == 9);
      @(negedge CLK);
      chk("s5_busy", 32'(busy), 1);
      tick();
    end
    start = 1'b0; stop = 1'b0;
    @(negedge CLK);
    chk("s5_valid_low", 32'(out_valid), 0);
    chk("s5_done", 32'(done), 1);
    chk("s5_beats", beats_sent, 10);
    chk("s5_accepts", acc_cnt - acc0, 10);
    tick();
    flush_model();
    tick();

    // RESET after two accepts: everything clears with no done pulse.
    start_stream('h0A0, 8, 1'b1, 8);
    repeat (2) begin
      @(negedge CLK);
      tick();
    end
    RESET = 1'b1;
    tick();
    @(negedge CLK);
    chk("s6_valid", 32'(out_valid), 0);
    chk("s6_busy", 32'(busy), 0);
    chk("s6_done", 32'(done), 0);
    chk("s6_patch_num", 32'(patch_num), 0);
    chk("s6_wtsum", 32'(wtsum), 0);
    chk("s6_beats", beats_sent, 0);
    flush_model();
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    chk("s6_no_done", 32'(done), 0);
    tick();
    start_stream(0, 2, 1'b0, 2);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("s6_restart_pn", 32'(patch_num), lit_pn[i]);
      tick();
    end
    wait_done("s6_restart_done", 5);
    chk("s6_restart_beats", beats_sent, 2);
    chk("s6_queue_empty", exp_pn_q.size(), 0);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/patch_stim_gen.md
Name: patch_stim_gen

Overview:
Parametrised stimulus source for the patch/weighted-sum application path. It generates a stream of (patch_num, wtsum) beats from either an XNOR LFSR or a sequential patch counter. Streams are seeded, length-limited or free-running, and delivered over a valid/ready handshake. It replaces the hard-wired 12-bit free-running LFSR in top-level hardware and simulation harnesses.

Parameters:
DELAY, 1, non-blocking assignment delay for simulation
LFSR_W, 12, LFSR width (legal 4..16)
TAPS, 12'hE08, feedback tap mask over LFSR bits (default taps 11,10,9,3)
N_PATCH, 600000, patch count; counter wraps at N_PATCH-1
PN_W, 20, patch_num width; must be >= log2(N_PATCH) and >= LFSR_W
FP_SIZE, 20, wtsum width; must be >= LFSR_W+4
EXP, 4'b1000, fixed exponent field inserted into wtsum
CNT_W, 32, beat count / beat counter width

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a stream; honoured only in IDLE
mode  in  1  0 = LFSR patch_num, 1 = sequential patch_num
seed  in  LFSR_W  LFSR seed, latched on start
count  in  CNT_W  number of beats; 0 = free-run until stop
stop  in  1  abort / end a free-run stream
out_valid  out  1  beat available
out_ready  in  1  consumer accepts beat
patch_num  out  PN_W  patch index
wtsum  out  FP_SIZE  weighted-sum word
busy  out  1  high in RUN
done  out  1  one-cycle pulse at end of stream
beats_sent  out  CNT_W  beats accepted in current/last stream

Behaviour:
- Reset values: all outputs 0; LFSR 0; counter 0; state IDLE.
- States: IDLE -> RUN on start; RUN -> DONE on last accept or stop; DONE -> IDLE unconditionally after 1 cycle.
- start:
  - Honoured only in IDLE; ignored in RUN and DONE.
  - On start, LFSR <= seed. If seed is all-ones (XNOR lock-up), 0 is loaded instead.
  - Patch counter <= 0; beats_sent <= 0; remaining <= count.
  - mode is latched on start and held for the whole stream.
- Latency: start at cycle t -> busy=1 and out_valid=1 at t+1, carrying the first beat.
- Beat format:
  - LFSR mode: patch_num = zero-extended LFSR.
  - Sequential mode: patch_num = counter.
  - Both modes: wtsum = {L[LFSR_W-1], EXP, L[LFSR_W-2:0], zeros to FP_SIZE}, where L is the LFSR.
- LFSR step: L <= {L[LFSR_W-2:0], ~^(L & TAPS)}.
- Handshake:
  - A beat is accepted when out_valid && out_ready.
  - On accept: LFSR steps, counter increments (N_PATCH-1 wraps to 0), beats_sent increments, remaining decrements if count != 0.
  - While out_valid && !out_ready, patch_num and wtsum hold stable.
  - out_valid never drops without an accept, except on stop or RESET.
- End of stream:
  - An accept with remaining==1 ends the stream: at the next cycle out_valid=0, busy=0, done=1 (DONE state).
  - With count==0, the stream runs until stop.
- stop:
  - stop in RUN ends the stream next cycle: out_valid=0, done=1.
  - A beat accepted in the same cycle as stop is counted in beats_sent.
  - stop in IDLE or DONE is ignored.
- Edge cases:
  - start with count==0 and stop already high in the cycle after start: exactly 0 or 1 beat, depending on out_ready in that cycle.
  - RESET mid-stream: immediate return to reset values; no done pulse.
  - beats_sent holds its value in IDLE until the next start.
  - beats_sent wraps at 2^CNT_W; the wrap is not flagged.
- Simulation-only assertion: 2**LFSR_W <= N_PATCH when mode==0, so patch_num < N_PATCH.

Test Plan:
- Reset then start, seed=0, count=5, mode=0, out_ready=1 -> patch_num 0x000,0x001,0x003,0x007,0x00F; wtsum 0x40000,0x40010,0x40030,0x40070,0x400F0; done one cycle after 5th accept; beats_sent=5.
- Seed=0xFFF -> first patch_num 0x000 (lock-up substitution); seed=0x800 -> first wtsum 0xC0000.
- mode=1, count=4, out_ready toggling 1,0,0,1,1,0,1 -> patch_num 0,1,2,3; values held across stalls; exactly 4 accepts; done after the 4th.
- mode=1, count=3 with N_PATCH overridden to 2 -> patch_num 0,1,0 (wrap).
- count=0, out_ready=1, stop asserted after 10 accepts (in the same cycle as the 10th) -> beats_sent=10, out_valid low next cycle, done pulse; start during RUN ignored.
- RESET asserted mid-stream after 2 accepts -> all outputs 0 next cycle, no done pulse; new start works normally.
